mult_seq_8bits: RTL and testbench



---
 rtl/mult_seq_8bits.sv | 147 ++++++++++++++
 tb/tb_mult_seq_8bits.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_8bits.sv
// mult_seq_8bits: sequential 8x8 unsigned shift-and-add multiplier.
//
// One shared 8-bit ripple-carry adder (SomComp8bits) is used once per cycle
// for eight cycles to build a 16-bit product. Requests come in through a
// start/done handshake.
//
// Ports:
//   clk    in   1   single clock, rising edge
//   rst    in   1   synchronous reset, active-high
//   start  in   1   request; only sampled while idle
//   A      in   8   multiplicand (unsigned), latched on accepted start
//   B      in   8   multiplier (unsigned), latched on accepted start
//   P      out  16  registered product, held until the next completion
//   busy   out  1   high while an operation is in flight (CALC and DONE)
//   done   out  1   one-cycle pulse; P is new and valid in that cycle

// SomComp8bits: 8-bit ripple-carry adder with carry-in and carry-out.
//
// Ports:
//   a, b   in   8   addends
//   cin    in   1   carry-in
//   sum    out  8   sum
//   cout   out  1   carry-out
module SomComp8bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

module mult_seq_8bits (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] P,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  m;
  logic [7:0]  acc;
  logic [7:0]  q;
  logic [2:0]  cnt;

  logic [7:0]  sum;
  logic        co;
  logic        c_bit;
  logic [7:0]  x;
  logic [15:0] shifted;

  SomComp8bits u_adder (
    .a    (acc),
    .b    (m),
    .cin  (1'b0),
    .sum  (sum),
    .cout (co)
  );

  // Partial-product step: add M only when the current multiplier bit is set.
  // The adder's carry-out becomes the top bit of the 17-bit {C,X,Q} value, so
  // it must survive into the shift rather than being truncated.
  always_comb begin
    if (q[0]) begin
      c_bit = co;
      x     = sum;
    end else begin
      c_bit = 1'b0;
      x     = acc;
    end
    shifted = {c_bit, x, q[7:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      cnt   <= '0;
      P     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            m     <= A;
            q     <= B;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end

        CALC: begin
          {acc, q} <= shifted;
          cnt      <= cnt + 3'd1;
          // Eighth iteration: the shifted value is the finished product.
          if (cnt == 3'd7) begin
            P     <= shifted;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_8bits.sv
// Self-checking testbench for mult_seq_8bits. Inputs change on the falling
// edge and outputs are sampled on the falling edge, away from the active edge.
module tb_mult_seq_8bits;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] P;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  mult_seq_8bits dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Issue one operation accepted at the next rising edge (edge k) and return
  // at the falling edge where done is seen; lat counts edges after edge k.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] p, output int lat);
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    p = P;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (P !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_P: actual=%h required=0000", P);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: actual=%b required=0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_done: actual=%b required=0", done);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [15:0] p;
    int lat;
    do_op(8'd13, 8'd11, p, lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("[TB] FAIL basic_latency: actual=%0d required=8", lat);
    end
    checks++;
    if (p !== 16'h008F) begin
      errors++;
      $display("[TB] FAIL basic_P: actual=%h required=008f", p);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_busy_in_done: actual=%b required=1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_after_done: actual busy=%b done=%b required busy=0 done=0", busy, done);
    end
    checks++;
    if (P !== 16'h008F) begin
      errors++;
      $display("[TB] FAIL basic_P_hold: actual=%h required=008f", P);
    end
  endtask

  task automatic test_corners;
    logic [15:0] p;
    int lat;
    do_op(8'hFF, 8'hFF, p, lat);
    checks++;
    if (p !== 16'hFE01 || lat !== 8) begin
      errors++;
      $display("[TB] FAIL ff_x_ff: actual P=%h lat=%0d required P=fe01 lat=8", p, lat);
    end
    do_op(8'h00, 8'h5A, p, lat);
    checks++;
    if (p !== 16'h0000 || lat !== 8) begin
      errors++;
      $display("[TB] FAIL zero_x_5a: actual P=%h lat=%0d required P=0000 lat=8", p, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_done;
    logic exp_busy;
    @(negedge clk);
    @(negedge clk);
    A     = 8'd200;
    B     = 8'd3;
    start = 1'b1;
    @(posedge clk);
    for (int idx = 0; idx <= 28; idx++) begin
      @(negedge clk);
      exp_done = (idx % 10 == 8);
      exp_busy = (idx % 10 != 9);
      checks++;
      if (done !== exp_done || busy !== exp_busy) begin
        errors++;
        $display("[TB] FAIL b2b_handshake idx=%0d: actual done=%b busy=%b required done=%b busy=%b",
                 idx, done, busy, exp_done, exp_busy);
      end
      if (exp_done) begin
        checks++;
        if (P !== 16'd600) begin
          errors++;
          $display("[TB] FAIL b2b_P idx=%0d: actual=%0d required=600", idx, P);
        end
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle: actual busy=%b required=0", busy);
    end
  endtask

  task automatic test_ignored_start;
    int done_count;
    done_count = 0;
    @(negedge clk);
    A     = 8'd7;
    B     = 8'd9;
    start = 1'b1;
    @(posedge clk);
    for (int idx = 0; idx <= 20; idx++) begin
      @(negedge clk);
      if (done) done_count++;
      if (idx == 8) begin
        checks++;
        if (done !== 1'b1 || P !== 16'd63) begin
          errors++;
          $display("[TB] FAIL ignored_start_result: actual done=%b P=%0d required done=1 P=63", done, P);
        end
      end
      if (idx >= 9) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL ignored_start_busy idx=%0d: actual=%b required=0", idx, busy);
        end
      end
      // Requests during CALC (idx 3) and during DONE (idx 8) must be dropped.
      if (idx == 0 || idx == 4 || idx == 9) begin
        start = 1'b0;
      end else if (idx == 3 || idx == 8) begin
        A     = 8'd1;
        B     = 8'd1;
        start = 1'b1;
      end
    end
    checks++;
    if (done_count !== 1) begin
      errors++;
      $display("[TB] FAIL ignored_start_done_count: actual=%0d required=1", done_count);
    end
    checks++;
    if (P !== 16'd63) begin
      errors++;
      $display("[TB] FAIL ignored_start_P_hold: actual=%0d required=63", P);
    end
  endtask

  task automatic test_reset_abort;
    logic [15:0] p;
    int lat;
    int done_count;
    done_count = 0;
    @(negedge clk);
    A     = 8'd10;
    B     = 8'd10;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (P !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_state: actual P=%h busy=%b done=%b required P=0000 busy=0 done=0",
               P, busy, done);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_count++;
    end
    checks++;
    if (done_count !== 0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: actual=%0d required=0", done_count);
    end
    do_op(8'd2, 8'd128, p, lat);
    checks++;
    if (p !== 16'd256 || lat !== 8) begin
      errors++;
      $display("[TB] FAIL abort_restart: actual P=%0d lat=%0d required P=256 lat=8", p, lat);
    end
  endtask

  task automatic test_sweep;
    logic [7:0]  corner [4];
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic [15:0] exp_p;
    int lat;
    corner[0] = 8'h00;
    corner[1] = 8'h01;
    corner[2] = 8'h80;
    corner[3] = 8'hFF;
    for (int i = 0; i < 1016; i++) begin
      if (i < 16) begin
        a = corner[i / 4];
        b = corner[i % 4];
      end else begin
        a = 8'($urandom_range(255));
        b = 8'($urandom_range(255));
      end
      exp_p = 16'(a) * 16'(b);
      do_op(a, b, p, lat);
      checks++;
      if (p !== exp_p || lat !== 8) begin
        errors++;
        $display("[TB] FAIL sweep %0d*%0d: actual P=%0d lat=%0d required P=%0d lat=8",
                 a, b, p, lat, exp_p);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    A      = '0;
    B      = '0;
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_ignored_start();
    test_reset_abort();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
